// File: rtl/ex_pkg.sv
// Shared constants for the execute stage: ALU op codes, R-type funct values,
// ex_ctl bit positions and the multiplier FSM state type.
package ex_pkg;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_MUL = 6'b011000;

  localparam int CTL_REGDST   = 3;
  localparam int CTL_ALUOP_HI = 2;
  localparam int CTL_ALUOP_LO = 1;
  localparam int CTL_ALUSRC   = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/iter_mult.sv
// Iterative shift-add multiplier, one multiplier bit per cycle; acc holds the
// low W bits of the product while done is high.
module iter_mult
  import ex_pkg::*;
#(
  parameter int W      = 32,
  parameter int CYCLES = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] acc
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  mul_state_t    state, state_next;
  logic [W-1:0]  mcand, mplier, acc_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: if (start) state_next = ST_MUL;
      ST_MUL: begin
        busy = 1'b1;
        if (cnt == LAST) state_next = ST_DONE;
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Multiplicand shifts left while the multiplier shifts right, so bit 0 of
  // mplier always selects whether the current partial product is added.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc_q  <= '0;
      cnt    <= '0;
    end else if (state == ST_IDLE && start) begin
      mcand  <= a;
      mplier <= b;
      acc_q  <= '0;
      cnt    <= '0;
    end else if (state == ST_MUL) begin
      if (mplier[0]) acc_q <= acc_q + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/ex_mem_stage.sv
// Execute stage and EX/MEM pipeline register. Define EX_MULT_EN to include the
// iterative multiplier and its stall; otherwise funct MUL yields 0 and stall is 0.
module ex_mem_stage
  import ex_pkg::*;
#(
  parameter int W          = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   wb_ctlout,
  input  logic [2:0]   m_ctlout,
  input  logic [3:0]   ex_ctlout,
  input  logic [W-1:0] npcout,
  input  logic [W-1:0] rdata1out,
  input  logic [W-1:0] rdata2out,
  input  logic [W-1:0] s_extendout,
  input  logic [4:0]   instrout_2016,
  input  logic [4:0]   instrout_1511,
  output logic         stall,
  output logic [1:0]   wb_ctl,
  output logic [2:0]   m_ctl,
  output logic [W-1:0] add_result,
  output logic         zero,
  output logic [W-1:0] alu_result,
  output logic [W-1:0] rdata2_ex,
  output logic [4:0]   dest_reg
);

  if (MUL_CYCLES != W) begin : g_bad_cfg
    $error("ex_mem_stage: MUL_CYCLES must equal W");
  end

  logic [1:0]   aluop;
  logic [5:0]   funct;
  logic [W-1:0] op_b;
  logic [W-1:0] alu_value;
  logic [W-1:0] branch_target;
  logic [4:0]   dest_sel;

  assign aluop         = ex_ctlout[CTL_ALUOP_HI:CTL_ALUOP_LO];
  assign funct         = s_extendout[5:0];
  assign op_b          = ex_ctlout[CTL_ALUSRC] ? s_extendout : rdata2out;
  assign dest_sel      = ex_ctlout[CTL_REGDST] ? instrout_1511 : instrout_2016;
  assign branch_target = npcout + (s_extendout << 2);

`ifdef EX_MULT_EN
  logic         is_mul;
  logic         mult_busy;
  logic         mult_done;
  logic [W-1:0] mult_acc;

  assign is_mul = (aluop == ALUOP_R) && (funct == FN_MUL);

  iter_mult #(
    .W      (W),
    .CYCLES (MUL_CYCLES)
  ) u_mult (
    .clk   (clk),
    .rst   (rst),
    .start (is_mul),
    .a     (rdata1out),
    .b     (op_b),
    .busy  (mult_busy),
    .done  (mult_done),
    .acc   (mult_acc)
  );

  // A mul seen while idle stalls in that very cycle; the DONE cycle does not.
  assign stall = !rst && ((is_mul && !mult_busy && !mult_done) || mult_busy);
`else
  assign stall = 1'b0;
`endif

  always_comb begin
    alu_value = '0;
    case (aluop)
      ALUOP_SUB: alu_value = rdata1out - op_b;
      ALUOP_R: begin
        case (funct)
          FN_ADD: alu_value = rdata1out + op_b;
          FN_SUB: alu_value = rdata1out - op_b;
          FN_AND: alu_value = rdata1out & op_b;
          FN_OR:  alu_value = rdata1out | op_b;
          FN_SLT: alu_value = {{(W-1){1'b0}}, ($signed(rdata1out) < $signed(op_b))};
`ifdef EX_MULT_EN
          FN_MUL: alu_value = mult_acc;
`endif
          default: alu_value = '0;
        endcase
      end
      default: alu_value = rdata1out + op_b;
    endcase
  end

  // While stalled the register inserts a bubble by clearing only the controls.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_ctl     <= '0;
      m_ctl      <= '0;
      add_result <= '0;
      zero       <= 1'b0;
      alu_result <= '0;
      rdata2_ex  <= '0;
      dest_reg   <= '0;
    end else if (stall) begin
      wb_ctl <= '0;
      m_ctl  <= '0;
    end else begin
      wb_ctl     <= wb_ctlout;
      m_ctl      <= m_ctlout;
      add_result <= branch_target;
      zero       <= (alu_value == '0);
      alu_result <= alu_value;
      rdata2_ex  <= rdata2out;
      dest_reg   <= dest_sel;
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed self-checking bench for ex_mem_stage; multiply sequences are
// exercised only when EX_MULT_EN is defined.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  wb_ctlout;
  logic [2:0]  m_ctlout;
  logic [3:0]  ex_ctlout;
  logic [31:0] npcout, rdata1out, rdata2out, s_extendout;
  logic [4:0]  instrout_2016, instrout_1511;
  logic        stall;
  logic [1:0]  wb_ctl;
  logic [2:0]  m_ctl;
  logic [31:0] add_result, alu_result, rdata2_ex;
  logic        zero;
  logic [4:0]  dest_reg;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  ex_mem_stage #(.W(32), .MUL_CYCLES(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .wb_ctlout     (wb_ctlout),
    .m_ctlout      (m_ctlout),
    .ex_ctlout     (ex_ctlout),
    .npcout        (npcout),
    .rdata1out     (rdata1out),
    .rdata2out     (rdata2out),
    .s_extendout   (s_extendout),
    .instrout_2016 (instrout_2016),
    .instrout_1511 (instrout_1511),
    .stall         (stall),
    .wb_ctl        (wb_ctl),
    .m_ctl         (m_ctl),
    .add_result    (add_result),
    .zero          (zero),
    .alu_result    (alu_result),
    .rdata2_ex     (rdata2_ex),
    .dest_reg      (dest_reg)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] wb, input logic [2:0] m, input logic [3:0] ex,
                               input logic [31:0] npc, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] sext, input logic [4:0] rt, input logic [4:0] rd);
    wb_ctlout     = wb;
    m_ctlout      = m;
    ex_ctlout     = ex;
    npcout        = npc;
    rdata1out     = a;
    rdata2out     = b;
    s_extendout   = sext;
    instrout_2016 = rt;
    instrout_1511 = rd;
    #1;
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  // ex_ctl encodings: {regdst, aluop[1:0], alusrc}
  localparam logic [3:0] EX_RTYPE  = 4'b1100;
  localparam logic [3:0] EX_BRANCH = 4'b0011;
  localparam logic [3:0] EX_ADDI   = 4'b0111;
  localparam logic [3:0] EX_ADD    = 4'b0000;

  initial begin
    rst = 1'b1;
    applyStimulus(2'($urandom), 3'($urandom), 4'($urandom), $urandom, $urandom, $urandom,
                  $urandom, 5'($urandom), 5'($urandom));
    stepClock();
    stepClock();
    checkOutput("rst_stall", {31'd0, stall}, 32'd0);
    checkOutput("rst_wb", {30'd0, wb_ctl}, 32'd0);
    checkOutput("rst_m", {29'd0, m_ctl}, 32'd0);
    checkOutput("rst_add", add_result, 32'd0);
    checkOutput("rst_zero", {31'd0, zero}, 32'd0);
    checkOutput("rst_alu", alu_result, 32'd0);
    checkOutput("rst_rdata2", rdata2_ex, 32'd0);
    checkOutput("rst_dest", {27'd0, dest_reg}, 32'd0);
    rst = 1'b0;

    // R-type add, rd selected, npc + (0x20<<2)
    applyStimulus(2'd1, 3'd2, EX_RTYPE, 32'h100, 32'd5, 32'd6, 32'h20, 5'd4, 5'd9);
    checkOutput("add_stall", {31'd0, stall}, 32'd0);
    stepClock();
    checkOutput("add_alu", alu_result, 32'd11);
    checkOutput("add_dest", {27'd0, dest_reg}, 32'd9);
    checkOutput("add_wb", {30'd0, wb_ctl}, 32'd1);
    checkOutput("add_m", {29'd0, m_ctl}, 32'd2);
    checkOutput("add_zero", {31'd0, zero}, 32'd0);
    checkOutput("add_target", add_result, 32'h180);
    checkOutput("add_rdata2", rdata2_ex, 32'd6);

    // Branch compare: sub with immediate, rt selected
    applyStimulus(2'd0, 3'd4, EX_BRANCH, 32'd4, 32'd7, 32'h55, 32'd7, 5'd3, 5'd12);
    stepClock();
    checkOutput("br_alu", alu_result, 32'd0);
    checkOutput("br_zero", {31'd0, zero}, 32'd1);
    checkOutput("br_target", add_result, 32'd32);
    checkOutput("br_dest", {27'd0, dest_reg}, 32'd3);
    checkOutput("br_rdata2", rdata2_ex, 32'h55);
    checkOutput("br_m", {29'd0, m_ctl}, 32'd4);

    applyStimulus(2'd1, 3'd0, EX_RTYPE, 32'd0, 32'hFFFF_FFFF, 32'd1, 32'h2A, 5'd1, 5'd2);
    stepClock();
    checkOutput("slt_neg", alu_result, 32'd1);
    applyStimulus(2'd1, 3'd0, EX_RTYPE, 32'd0, 32'd1, 32'hFFFF_FFFF, 32'h2A, 5'd1, 5'd2);
    stepClock();
    checkOutput("slt_swap", alu_result, 32'd0);
    checkOutput("slt_swap_zero", {31'd0, zero}, 32'd1);

    applyStimulus(2'd1, 3'd0, EX_RTYPE, 32'd0, 32'd3, 32'd5, 32'h22, 5'd1, 5'd2);
    stepClock();
    checkOutput("sub_wrap", alu_result, 32'hFFFF_FFFE);
    applyStimulus(2'd1, 3'd0, EX_RTYPE, 32'd0, 32'hF0F0, 32'hFF00, 32'h24, 5'd1, 5'd2);
    stepClock();
    checkOutput("and", alu_result, 32'h0000_F000);
    applyStimulus(2'd1, 3'd0, EX_RTYPE, 32'd0, 32'hF0F0, 32'hFF00, 32'h25, 5'd1, 5'd2);
    stepClock();
    checkOutput("or", alu_result, 32'h0000_FFF0);
    applyStimulus(2'd1, 3'd0, EX_RTYPE, 32'd0, 32'hF0F0, 32'hFF00, 32'h27, 5'd1, 5'd2);
    stepClock();
    checkOutput("bad_funct", alu_result, 32'd0);

    // aluop 11 adds the immediate; negative immediate also wraps the branch target
    applyStimulus(2'd2, 3'd1, EX_ADDI, 32'd8, 32'd10, 32'd0, 32'hFFFF_FFFF, 5'd7, 5'd8);
    stepClock();
    checkOutput("addi_alu", alu_result, 32'd9);
    checkOutput("addi_target", add_result, 32'd4);
    checkOutput("addi_dest", {27'd0, dest_reg}, 32'd7);

    applyStimulus(2'd1, 3'd1, EX_ADD, 32'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd1, 5'd2);
    stepClock();
    checkOutput("add_wrap", alu_result, 32'd0);
    checkOutput("add_wrap_zero", {31'd0, zero}, 32'd1);

    applyStimulus(2'd0, 3'd0, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
    stepClock();
    checkOutput("bubble_alu", alu_result, 32'd0);
    checkOutput("bubble_zero", {31'd0, zero}, 32'd1);
    checkOutput("bubble_wb", {30'd0, wb_ctl}, 32'd0);
    checkOutput("bubble_target", add_result, 32'd0);

`ifdef EX_MULT_EN
    begin
      int stall_cycles;
      applyStimulus(2'd3, 3'd5, EX_RTYPE, 32'd0, 32'h10001, 32'h30003, 32'h18, 5'd1, 5'd6);
      stall_cycles = 0;
      while (stall && stall_cycles < 50) begin
        if (stall_cycles == 1) begin
          checkOutput("mul_bubble_wb", {30'd0, wb_ctl}, 32'd0);
          checkOutput("mul_bubble_m", {29'd0, m_ctl}, 32'd0);
        end
        stall_cycles++;
        stepClock();
      end
      checkOutput("mul_stall_cycles", stall_cycles, 32'd33);
      stepClock();
      checkOutput("mul_result", alu_result, 32'h0006_0003);
      checkOutput("mul_wb", {30'd0, wb_ctl}, 32'd3);
      checkOutput("mul_m", {29'd0, m_ctl}, 32'd5);
      checkOutput("mul_dest", {27'd0, dest_reg}, 32'd6);
      applyStimulus(2'd1, 3'd0, EX_RTYPE, 32'd0, 32'd2, 32'd3, 32'h20, 5'd1, 5'd4);
      checkOutput("post_mul_stall", {31'd0, stall}, 32'd0);
      stepClock();
      checkOutput("post_mul_add", alu_result, 32'd5);

      applyStimulus(2'd3, 3'd5, EX_RTYPE, 32'd0, 32'd7, 32'd9, 32'h18, 5'd1, 5'd6);
      for (int i = 0; i < 10; i++) stepClock();
      checkOutput("midmul_stall", {31'd0, stall}, 32'd1);
      rst = 1'b1;
      #1;
      checkOutput("midmul_rst_stall", {31'd0, stall}, 32'd0);
      stepClock();
      rst = 1'b0;
      checkOutput("midmul_rst_alu", alu_result, 32'd0);
      checkOutput("midmul_rst_wb", {30'd0, wb_ctl}, 32'd0);
      applyStimulus(2'd1, 3'd2, EX_RTYPE, 32'd0, 32'd20, 32'd22, 32'h20, 5'd1, 5'd5);
      checkOutput("after_rst_stall", {31'd0, stall}, 32'd0);
      stepClock();
      checkOutput("after_rst_add", alu_result, 32'd42);
      checkOutput("after_rst_wb", {30'd0, wb_ctl}, 32'd1);
    end
`else
    applyStimulus(2'd3, 3'd5, EX_RTYPE, 32'd0, 32'h10001, 32'h30003, 32'h18, 5'd1, 5'd6);
    checkOutput("nomul_stall", {31'd0, stall}, 32'd0);
    stepClock();
    checkOutput("nomul_alu", alu_result, 32'd0);
    checkOutput("nomul_wb", {30'd0, wb_ctl}, 32'd3);
    checkOutput("nomul_zero", {31'd0, zero}, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
